lea_key_sched_ctrl: RTL
=======================

Name: lea_key_sched_ctrl

Overview:
Sequential LEA key-schedule engine and controller. It byte-reorders the input key, iterates the LEA key-schedule recurrence at one round key per clock, and stores the round keys in a local register file. The LEA round datapath reads that register file by round index, and may start as soon as a given key is counted as written.

Parameters:
KEY_LEN, 128, key length in bits; legal values 128/192/256, any other value is an elaboration $error.
NR, derived (24/28/32 for KEY_LEN 128/192/256), number of rounds; localparam, not overridable.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst=0 resets on rising clk edge)
key  in  KEY_LEN  cipher key; 32-bit word i = key[32i+31:32i]
start  in  1  request key generation; sampled only in IDLE
busy  out  1  high in LOAD and GEN
end_key_generation  out  1  high in DONE; all NR round keys valid
rk_count  out  6  number of round keys written since last start
rk_rd_idx  in  5  round-key read index
rk_rd_data  out  192  round key rk_mem[rk_rd_idx]; combinational read; word j = bits[32j+31:32j]

Behaviour:
- Reset (rst=0): state=IDLE, busy=0, end_key_generation=0, rk_count=0. rk_mem is not cleared; end_key_generation=0 marks it invalid. Reset mid-GEN aborts immediately with no further writes.
- FSM: IDLE -(start)-> LOAD -> GEN -(cnt==NR-1 written)-> DONE -(start)-> LOAD. In DONE, start has the same effect as in IDLE. start in LOAD/GEN is ignored.
- LOAD (1 cycle):
  - T[i] <= byte-reversed key word i, for i < KEY_LEN/32. Byte reversal: {w[7:0],w[15:8],w[23:16],w[31:24]}.
  - cnt<=0, rk_count<=0, end_key_generation<=0.
- GEN (NR cycles): each cycle i=cnt computes round key i from T combinationally, writes rk_mem[i], updates T, then cnt++ and rk_count++.
  - 128: d=DELTA[i mod 4].
    - T0=ROL(T0+ROL(d,i),1), T1=ROL(T1+ROL(d,i+1),3), T2=ROL(T2+ROL(d,i+2),6), T3=ROL(T3+ROL(d,i+3),11).
    - RK={T0,T1,T2,T1,T3,T1}, word0 first.
  - 192: d=DELTA[i mod 6].
    - Tj=ROL(Tj+ROL(d,i+j),R[j]) for j=0..5, with R={1,3,6,11,13,17}.
    - RK={T0..T5}.
  - 256: d=DELTA[i mod 8].
    - For j=0..5: k=(6i+j) mod 8, T[k]=ROL(T[k]+ROL(d,i+j),R[j]).
    - RK word j = new T[k].
  - All additions are mod 2^32. Rotate amounts are taken mod 32 (5-bit).
- Latency: start high in IDLE at edge t gives LOAD at t+1, GEN over t+2..t+NR+1, and end_key_generation=1 from edge t+NR+2. It is a level signal, held until the next accepted start or reset.
- rk_count updates one edge after each write. Round key j is readable once rk_count > j, so the datapath may pipeline behind generation.
- rk_rd_idx >= NR returns 192'h0.
- key is sampled only in LOAD; later changes have no effect until the next start.

Optional Feature:
Macro LEA_KEY_CACHE_EN.
- Defined:
  - Keep a register of the last fully generated key plus a cache_valid flag. cache_valid is cleared by reset and by abort.
  - start with key == cached key and cache_valid=1 goes IDLE/DONE -> DONE in 1 cycle: end_key_generation=1 at t+1, rk_count=NR, no rk_mem writes.
  - Otherwise normal flow; cache_valid is set on entering DONE.
- Not defined: no key register or comparator; every start regenerates (NR+2 cycles).

Decomposition:
- Package lea_pkg:
  - DELTA[0:7] = c3efe9db, 44626b02, 79e27c8a, 78df30ec, 715ea49e, c785da0a, e04ef22a, e5c40957.
  - Rotate table R.
  - NR as a function of KEY_LEN.
  - rol32 and byte-reverse functions.
  - State enum typedef.
- Sub-module lea_ks_round (combinational): inputs T state, i, KEY_LEN; outputs next T and 192-bit RK. The controller holds the FSM, counters, rk_mem and the cache.

Test Plan:
- KEY_LEN=128, key=0, start pulse -> end_key_generation rises exactly 26 cycles after the start edge; rk_mem[0] words 0..5 = 87dfd3b7, 3efe9dbc, efe9dbc3, 3efe9dbc, fa76f0fb, 3efe9dbc.
- KEY_LEN 128/192/256 with KISA test-vector keys -> all NR round keys match the golden model; rk_rd_idx=31 with KEY_LEN=128 returns 0.
- Assert start every cycle during GEN -> ignored; rk_count counts 1..NR monotonically; busy=1 for exactly NR+1 cycles.
- rst=0 at GEN cycle 10 -> next edge: busy=0, end_key_generation=0, rk_count=0; a restart regenerates correct keys.
- Change key mid-GEN -> output still matches the key sampled in LOAD.
- LEA_KEY_CACHE_EN: repeat start with the same key -> end_key_generation after 1 cycle with no rk_mem writes. Different key -> full NR+2 cycles. Reset then same key -> full regeneration.

Source files
------------

// File: rtl/lea_pkg.sv
// Shared constants, helper functions and FSM state type for the LEA
// key-schedule engine.
package lea_pkg;

    localparam logic [31:0] DELTA [8] = '{
        32'hc3efe9db, 32'h44626b02, 32'h79e27c8a, 32'h78df30ec,
        32'h715ea49e, 32'hc785da0a, 32'he04ef22a, 32'he5c40957
    };

    localparam logic [4:0] ROT [6] = '{5'd1, 5'd3, 5'd6, 5'd11, 5'd13, 5'd17};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GEN,
        ST_DONE
    } ks_state_e;

    function automatic int nr_of(input int key_len);
        case (key_len)
            192:     return 28;
            256:     return 32;
            default: return 24;
        endcase
    endfunction

    // The upper half of the doubled word shifted left is the left rotation.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] dbl;
        dbl = {x, x} << amt;
        return dbl[63:32];
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/lea_ks_round.sv
// One step of the LEA key-schedule recurrence: next T state and round key i.
module lea_ks_round
    import lea_pkg::*;
#(
    parameter int KEY_LEN = 128
) (
    input  logic [7:0][31:0] t_i,
    input  logic [4:0]       idx_i,
    output logic [7:0][31:0] t_o,
    output logic [191:0]     rk_o
);

    localparam int NW = KEY_LEN / 32;

    logic [31:0] delta;

    // NOTE: blocking assignments inside always_comb; later statements see
    // the freshly updated t_o words, which the round-key packing relies on.
    always_comb begin
        delta = DELTA[3'(int'(idx_i) % NW)];
        t_o   = t_i;
        rk_o  = '0;
        if (KEY_LEN == 256) begin
            // Six of the eight words advance per round, in a sliding window.
            for (int j = 0; j < 6; j++) begin
                t_o[3'(6 * int'(idx_i) + j)] =
                    rol32(t_i[3'(6 * int'(idx_i) + j)] + rol32(delta, 5'(int'(idx_i) + j)), ROT[j]);
                rk_o[32*j +: 32] = t_o[3'(6 * int'(idx_i) + j)];
            end
        end else begin
            for (int j = 0; j < 6; j++) begin
                if (j < NW) begin
                    t_o[j] = rol32(t_i[j] + rol32(delta, 5'(int'(idx_i) + j)), ROT[j]);
                end
            end
            if (KEY_LEN == 128) begin
                rk_o = {t_o[1], t_o[3], t_o[1], t_o[2], t_o[1], t_o[0]};
            end else begin
                rk_o = {t_o[5], t_o[4], t_o[3], t_o[2], t_o[1], t_o[0]};
            end
        end
    end

endmodule

// File: rtl/lea_key_sched_ctrl.sv
// LEA key-schedule controller: FSM, counters, round-key register file and,
// when LEA_KEY_CACHE_EN is defined, a repeat-key cache that skips regeneration.
module lea_key_sched_ctrl
    import lea_pkg::*;
#(
    parameter int KEY_LEN = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_LEN-1:0] key,
    input  logic               start,
    output logic               busy,
    output logic               end_key_generation,
    output logic [5:0]         rk_count,
    input  logic [4:0]         rk_rd_idx,
    output logic [191:0]       rk_rd_data
);

    localparam int NR = nr_of(KEY_LEN);
    localparam int NW = KEY_LEN / 32;

    if (KEY_LEN != 128 && KEY_LEN != 192 && KEY_LEN != 256) begin : g_bad_key_len
        $error("lea_key_sched_ctrl: KEY_LEN must be 128, 192 or 256");
    end

    ks_state_e        state_q;
    logic [4:0]       cnt_q;
    logic [5:0]       rk_count_q;
    logic             busy_q;
    logic             done_q;
    logic [7:0][31:0] t_q;
    logic [7:0][31:0] t_d;
    logic [7:0][31:0] t_load;
    logic [191:0]     rk_d;
    logic [191:0]     rk_mem_q [NR];
    logic             start_hit;

`ifdef LEA_KEY_CACHE_EN
    logic [KEY_LEN-1:0] key_cache_q;
    logic               cache_valid_q;

    assign start_hit = cache_valid_q && (key == key_cache_q);

    // The cached key is the one loaded; it only counts once generation completes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_valid_q <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            cache_valid_q <= 1'b0;
        end else if (state_q == ST_GEN && cnt_q == 5'(NR - 1)) begin
            cache_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            key_cache_q <= key;
        end
    end
`else
    assign start_hit = 1'b0;
`endif

    // NOTE: every word gets a default before the loop so no latch is inferred.
    always_comb begin
        t_load = '0;
        for (int i = 0; i < NW; i++) begin
            t_load[i] = bswap32(key[32*i +: 32]);
        end
    end

    lea_ks_round #(
        .KEY_LEN (KEY_LEN)
    ) u_round (
        .t_i   (t_q),
        .idx_i (cnt_q),
        .t_o   (t_d),
        .rk_o  (rk_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rk_count_q <= '0;
            cnt_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start && start_hit) begin
                        state_q    <= ST_DONE;
                        done_q     <= 1'b1;
                        rk_count_q <= 6'(NR);
                    end else if (start) begin
                        state_q    <= ST_LOAD;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        rk_count_q <= '0;
                    end
                end
                ST_LOAD: begin
                    state_q    <= ST_GEN;
                    cnt_q      <= '0;
                    rk_count_q <= '0;
                    done_q     <= 1'b0;
                end
                ST_GEN: begin
                    cnt_q      <= cnt_q + 5'd1;
                    rk_count_q <= rk_count_q + 6'd1;
                    if (cnt_q == 5'(NR - 1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_LOAD) begin
            t_q <= t_load;
        end else if (state_q == ST_GEN) begin
            t_q <= t_d;
        end
    end

    // NOTE: rk_mem is deliberately not reset; end_key_generation=0 marks its
    // contents invalid. The rst term stops the write on an aborting edge.
    always_ff @(posedge clk) begin
        if (rst && state_q == ST_GEN) begin
            rk_mem_q[cnt_q] <= rk_d;
        end
    end

    assign rk_rd_data         = (int'(rk_rd_idx) < NR) ? rk_mem_q[rk_rd_idx] : '0;
    assign busy               = busy_q;
    assign end_key_generation = done_q;
    assign rk_count           = rk_count_q;

endmodule
